// File: rtl/z380_platform_pkg.sv
// Shared types and default sizing for the Z380 DRAM scheduler slice.
package z380_platform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_REF  = 2'd2
  } z380_sched_state_t;

  localparam int DEF_MAX_OWED    = 7;
  localparam int DEF_URGENT_OWED = 4;
  localparam int DEF_REF_CYCLES  = 6;

endpackage

// File: rtl/z380_dram_sched_if.sv
// CPU request / DRAM datapath handshake between the CPU side and the scheduler.
interface z380_dram_sched_if;
  logic cpu_req_valid;
  logic cpu_req_ready;
  logic mem_done;
  logic cpu_grant;
  logic ref_start;
  logic ref_active;

  modport master (
    output cpu_req_valid, mem_done,
    input  cpu_req_ready, cpu_grant, ref_start, ref_active
  );

  modport slave (
    input  cpu_req_valid, mem_done,
    output cpu_req_ready, cpu_grant, ref_start, ref_active
  );
endinterface

// File: rtl/z380_refresh_debt.sv
// Saturating owed-refresh counter: +1 per tick, -1 per completed refresh,
// sticky overflow when a tick is lost at saturation.
module z380_refresh_debt #(
  parameter int MAX_OWED = 7,
  parameter int OW       = $clog2(MAX_OWED + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic          done_i,
  input  logic          clr_i,
  output logic [OW-1:0] owed_o,
  output logic          ovf_o
);
  localparam logic [OW-1:0] MAX = OW'(MAX_OWED);

  logic [OW-1:0] owed_q, owed_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    owed_d = owed_q;
    // clear is applied first so a same-cycle overflow set takes precedence
    ovf_d  = ovf_q & ~clr_i;
    if (tick_i && !done_i) begin
      if (owed_q == MAX) ovf_d  = 1'b1;
      else               owed_d = owed_q + 1'b1;
    end else if (!tick_i && done_i && owed_q != '0) begin
      owed_d = owed_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owed_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      owed_q <= owed_d;
      ovf_q  <= ovf_d;
    end
  end

  assign owed_o = owed_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/z380_dram_sched.sv
// Arbitrates the single DRAM datapath between CPU accesses and refresh cycles,
// refreshing opportunistically when idle and preemptively once debt is urgent.
module z380_dram_sched
  import z380_platform_pkg::*;
#(
  parameter int MAX_OWED    = DEF_MAX_OWED,
  parameter int URGENT_OWED = DEF_URGENT_OWED,
  parameter int REF_CYCLES  = DEF_REF_CYCLES,
  parameter int OW          = $clog2(MAX_OWED + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              refresh_tick,
  input  logic              ovf_clr,
  output logic [OW-1:0]     owed,
  output logic              owed_ovf,
  z380_dram_sched_if.slave  bus
);
  localparam int             CW       = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REF_CYCLES - 1);
  localparam logic [OW-1:0]  URG      = OW'(URGENT_OWED);

  z380_sched_state_t state_q;
  logic [CW-1:0]     cnt_q;
  logic              grant_q, ref_start_q, ref_active_q;
  logic              ref_done;

  assign ref_done = (state_q == ST_REF) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      ref_start_q  <= 1'b0;
      ref_active_q <= 1'b0;
    end else begin
      ref_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (owed >= URG || (!bus.cpu_req_valid && owed != '0)) begin
            state_q      <= ST_REF;
            cnt_q        <= CNT_LAST;
            ref_start_q  <= 1'b1;
            ref_active_q <= 1'b1;
          end else if (bus.cpu_req_valid) begin
            state_q <= ST_CPU;
            grant_q <= 1'b1;
          end
        end
        ST_CPU: begin
          if (bus.mem_done) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
          end
        end
        ST_REF: begin
          // always return through IDLE so consecutive operations are separated
          if (cnt_q == '0) begin
            state_q      <= ST_IDLE;
            ref_active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          grant_q      <= 1'b0;
          ref_active_q <= 1'b0;
        end
      endcase
    end
  end

  z380_refresh_debt #(
    .MAX_OWED (MAX_OWED),
    .OW       (OW)
  ) u_debt (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (refresh_tick),
    .done_i (ref_done),
    .clr_i  (ovf_clr),
    .owed_o (owed),
    .ovf_o  (owed_ovf)
  );

  assign bus.cpu_req_ready = (state_q == ST_IDLE) && (owed < URG);
  assign bus.cpu_grant     = grant_q;
  assign bus.ref_start     = ref_start_q;
  assign bus.ref_active    = ref_active_q;
endmodule

// File: tb/tb_z380_dram_sched.sv
// Directed bench for z380_dram_sched with default parameters (7/4/6).
module tb_z380_dram_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       refresh_tick;
  logic       ovf_clr;
  logic [2:0] owed;
  logic       owed_ovf;
  int         checks = 0;
  int         failures = 0;

  z380_dram_sched_if bus ();

  z380_dram_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .refresh_tick (refresh_tick),
    .ovf_clr      (ovf_clr),
    .owed         (owed),
    .owed_ovf     (owed_ovf),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1ns after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 300 && !(owed == 3'd0 && !bus.ref_active && !bus.cpu_grant)) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout owed=%0d ref_active=%0b grant=%0b", owed, bus.ref_active, bus.cpu_grant);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; refresh_tick = 1'b0; ovf_clr = 1'b0;
    bus.cpu_req_valid = 1'b0; bus.mem_done = 1'b0;
    step(); step();
    checks++; if (owed !== 3'd0) begin failures++; $display("FAIL rst_owed got=%0d exp=0", owed); end
    checks++; if (owed_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", owed_ovf); end
    checks++; if (bus.cpu_grant !== 1'b0) begin failures++; $display("FAIL rst_grant got=%0b exp=0", bus.cpu_grant); end
    checks++; if (bus.ref_start !== 1'b0 || bus.ref_active !== 1'b0) begin failures++; $display("FAIL rst_ref got=%0b%0b exp=00", bus.ref_start, bus.ref_active); end
    checks++; if (bus.cpu_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", bus.cpu_req_ready); end
    rst_n = 1'b1;
    step();
    // stray mem_done in IDLE must do nothing
    bus.mem_done = 1'b1; step(); bus.mem_done = 1'b0;
    checks++; if (bus.cpu_grant !== 1'b0 || bus.ref_active !== 1'b0 || owed !== 3'd0) begin failures++; $display("FAIL stray_done grant=%0b ref=%0b owed=%0d exp=0/0/0", bus.cpu_grant, bus.ref_active, owed); end
  endtask

  task automatic test_idle_refresh();
    refresh_tick = 1'b1; step(); refresh_tick = 1'b0;
    checks++; if (owed !== 3'd1 || bus.ref_active !== 1'b0) begin failures++; $display("FAIL idle_tick owed=%0d ref=%0b exp=1/0", owed, bus.ref_active); end
    step();
    checks++; if (bus.ref_start !== 1'b1 || bus.ref_active !== 1'b1) begin failures++; $display("FAIL idle_ref_start start=%0b act=%0b exp=1/1", bus.ref_start, bus.ref_active); end
    step();
    checks++; if (bus.ref_start !== 1'b0 || bus.ref_active !== 1'b1) begin failures++; $display("FAIL idle_ref_c2 start=%0b act=%0b exp=0/1", bus.ref_start, bus.ref_active); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.ref_active !== 1'b1 || owed !== 3'd1) begin failures++; $display("FAIL idle_ref_hold i=%0d act=%0b owed=%0d exp=1/1", i, bus.ref_active, owed); end
    end
    step();
    checks++; if (bus.ref_active !== 1'b0 || owed !== 3'd0 || bus.cpu_req_ready !== 1'b1) begin failures++; $display("FAIL idle_ref_end act=%0b owed=%0d rdy=%0b exp=0/0/1", bus.ref_active, owed, bus.cpu_req_ready); end
  endtask

  task automatic test_cpu_first();
    bus.cpu_req_valid = 1'b1; refresh_tick = 1'b1; step();
    bus.cpu_req_valid = 1'b0; refresh_tick = 1'b0;
    checks++; if (bus.cpu_grant !== 1'b1 || owed !== 3'd1 || bus.ref_active !== 1'b0) begin failures++; $display("FAIL cpu_first grant=%0b owed=%0d ref=%0b exp=1/1/0", bus.cpu_grant, owed, bus.ref_active); end
    step();
    checks++; if (bus.cpu_grant !== 1'b1 || bus.cpu_req_ready !== 1'b0) begin failures++; $display("FAIL cpu_hold grant=%0b rdy=%0b exp=1/0", bus.cpu_grant, bus.cpu_req_ready); end
    bus.mem_done = 1'b1; step(); bus.mem_done = 1'b0;
    checks++; if (bus.cpu_grant !== 1'b0 || bus.ref_active !== 1'b0) begin failures++; $display("FAIL cpu_gap grant=%0b ref=%0b exp=0/0", bus.cpu_grant, bus.ref_active); end
    step();
    checks++; if (bus.ref_start !== 1'b1) begin failures++; $display("FAIL cpu_then_ref start=%0b exp=1", bus.ref_start); end
    drain();
    checks++; if (owed !== 3'd0) begin failures++; $display("FAIL cpu_then_ref_owed got=%0d exp=0", owed); end
  endtask

  task automatic test_urgent();
    int starts = 0;
    int rdy_owed = -1;
    int n = 0;
    bus.cpu_req_valid = 1'b1; step(); bus.cpu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      refresh_tick = 1'b1; step(); refresh_tick = 1'b0; step();
    end
    checks++; if (bus.cpu_grant !== 1'b1 || owed !== 3'd4) begin failures++; $display("FAIL urg_blocked grant=%0b owed=%0d exp=1/4", bus.cpu_grant, owed); end
    bus.mem_done = 1'b1; step(); bus.mem_done = 1'b0;
    checks++; if (bus.cpu_req_ready !== 1'b0 || owed !== 3'd4) begin failures++; $display("FAIL urg_ready rdy=%0b owed=%0d exp=0/4", bus.cpu_req_ready, owed); end
    while (n < 100 && !(owed == 3'd0 && !bus.ref_active)) begin
      step();
      n++;
      if (bus.ref_start) starts++;
      if (bus.cpu_req_ready && rdy_owed < 0) rdy_owed = int'(owed);
    end
    checks++; if (starts != 4) begin failures++; $display("FAIL urg_ref_count got=%0d exp=4", starts); end
    checks++; if (rdy_owed != 3) begin failures++; $display("FAIL urg_ready_owed got=%0d exp=3", rdy_owed); end
    bus.cpu_req_valid = 1'b1; step(); bus.cpu_req_valid = 1'b0;
    checks++; if (bus.cpu_grant !== 1'b1) begin failures++; $display("FAIL urg_cpu_after got=%0b exp=1", bus.cpu_grant); end
    bus.mem_done = 1'b1; step(); bus.mem_done = 1'b0;
  endtask

  task automatic test_saturate();
    bus.cpu_req_valid = 1'b1; step(); bus.cpu_req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      refresh_tick = 1'b1; step();
    end
    refresh_tick = 1'b0;
    checks++; if (owed !== 3'd7 || owed_ovf !== 1'b0) begin failures++; $display("FAIL sat_at_max owed=%0d ovf=%0b exp=7/0", owed, owed_ovf); end
    refresh_tick = 1'b1; step(); refresh_tick = 1'b0;
    checks++; if (owed !== 3'd7 || owed_ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf owed=%0d ovf=%0b exp=7/1", owed, owed_ovf); end
    ovf_clr = 1'b1; refresh_tick = 1'b1; step(); refresh_tick = 1'b0;
    checks++; if (owed_ovf !== 1'b1 || owed !== 3'd7) begin failures++; $display("FAIL sat_set_wins ovf=%0b owed=%0d exp=1/7", owed_ovf, owed); end
    step(); ovf_clr = 1'b0;
    checks++; if (owed_ovf !== 1'b0) begin failures++; $display("FAIL sat_clear got=%0b exp=0", owed_ovf); end
    bus.mem_done = 1'b1; step(); bus.mem_done = 1'b0;
    drain();
  endtask

  task automatic test_tick_on_last();
    bus.cpu_req_valid = 1'b1; step(); bus.cpu_req_valid = 1'b0;
    refresh_tick = 1'b1; step(); step(); refresh_tick = 1'b0;
    bus.mem_done = 1'b1; step(); bus.mem_done = 1'b0;
    checks++; if (owed !== 3'd2 || bus.cpu_grant !== 1'b0) begin failures++; $display("FAIL tol_setup owed=%0d grant=%0b exp=2/0", owed, bus.cpu_grant); end
    step();
    checks++; if (bus.ref_start !== 1'b1) begin failures++; $display("FAIL tol_start got=%0b exp=1", bus.ref_start); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus.ref_active !== 1'b1 || owed !== 3'd2) begin failures++; $display("FAIL tol_last act=%0b owed=%0d exp=1/2", bus.ref_active, owed); end
    refresh_tick = 1'b1; step(); refresh_tick = 1'b0;
    checks++; if (owed !== 3'd2 || bus.ref_active !== 1'b0) begin failures++; $display("FAIL tol_cancel owed=%0d act=%0b exp=2/0", owed, bus.ref_active); end
    step();
    checks++; if (bus.ref_start !== 1'b1) begin failures++; $display("FAIL tol_next_ref got=%0b exp=1", bus.ref_start); end
    drain();
  endtask

  task automatic test_reset_mid();
    refresh_tick = 1'b1; step(); refresh_tick = 1'b0;
    step(); step(); step();
    checks++; if (bus.ref_active !== 1'b1 || owed !== 3'd1) begin failures++; $display("FAIL rm_in_ref act=%0b owed=%0d exp=1/1", bus.ref_active, owed); end
    rst_n = 1'b0; #1;
    checks++; if (bus.ref_active !== 1'b0 || owed !== 3'd0 || bus.cpu_req_ready !== 1'b1) begin failures++; $display("FAIL rm_async act=%0b owed=%0d rdy=%0b exp=0/0/1", bus.ref_active, owed, bus.cpu_req_ready); end
    step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.ref_active !== 1'b0 || bus.cpu_grant !== 1'b0 || owed !== 3'd0) begin failures++; $display("FAIL rm_idle i=%0d act=%0b grant=%0b owed=%0d exp=0/0/0", i, bus.ref_active, bus.cpu_grant, owed); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_cpu_first();
    test_urgent();
    test_saturate();
    test_tick_on_last();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z380_dram_sched.md
# z380_dram_sched

Schedules the Z380 platform's single DRAM datapath between CPU memory accesses and refresh cycles. It counts `refresh_tick` pulses from the programmable refresh generator as owed refreshes, and issues those refreshes opportunistically while the CPU is idle. When the debt reaches an urgency threshold, refresh takes priority. The block sits between the refresh tick generator, the CPU memory request path and the DRAM cycle engine.

## Interface
Parameters:
- `MAX_OWED`, default 7: saturation value of the owed-refresh counter.
- `URGENT_OWED`, default 4: owed count at which refresh preempts new CPU requests. Legal range is 1..`MAX_OWED`.
- `REF_CYCLES`, default 6: duration of one refresh cycle in clocks. Must be ≥1.
- Derived `OW = $clog2(MAX_OWED+1)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous active-low reset.
- `refresh_tick` in 1: one-cycle pulse from the refresh generator; each pulse adds one owed refresh.
- `cpu_req_valid` in 1: CPU memory request pending.
- `cpu_req_ready` out 1: request accepted when `valid && ready`.
- `mem_done` in 1: DRAM engine finished the granted CPU access (one-cycle pulse).
- `cpu_grant` out 1: high while a CPU access owns the datapath.
- `ref_start` out 1: one-cycle pulse on the first cycle of a refresh.
- `ref_active` out 1: high for every cycle of a refresh.
- `owed` out `OW`: current owed-refresh count.
- `owed_ovf` out 1: sticky flag, set when a tick arrives with `owed == MAX_OWED`.
- `ovf_clr` in 1: clears `owed_ovf`.

## Operation
- FSM states are IDLE, CPU and REF. Reset state is IDLE.
- `cpu_req_ready = (state==IDLE) && (owed < URGENT_OWED)`. It is independent of `cpu_req_valid`.

IDLE decision, evaluated in priority order:
1. If `owed ≥ URGENT_OWED`, go to REF.
2. Else if `cpu_req_valid`, accept the request and go to CPU.
3. Else if `owed > 0`, go to REF.
4. Else stay in IDLE.

CPU state:
- `cpu_grant = 1`.
- Stay until `mem_done`; on `mem_done` go to IDLE.
- `mem_done` outside CPU state is ignored.

REF state:
- On entry, load the cycle counter with `REF_CYCLES-1`.
- `ref_active = 1` throughout; `ref_start = 1` only on the entry cycle.
- Decrement the counter each cycle. On the cycle the counter equals 0, decrement `owed` and go to IDLE.

Owed counter update, applied each cycle:
- `owed_next = owed + tick - completion`.
- A tick and a completion in the same cycle leave `owed` unchanged.
- If a tick arrives with `owed == MAX_OWED` and there is no completion that cycle, `owed` holds and `owed_ovf` sets.

Overflow flag:
- `ovf_clr` clears `owed_ovf`.
- If a set and `ovf_clr` occur in the same cycle, set wins.

Other rules:
- Ticks count in every state.
- The datapath is never shared: CPU and REF are mutually exclusive.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs except none. `cpu_req_ready` depends only on state and `owed`.
- Reset values: state IDLE, `owed` 0, `owed_ovf` 0, `cpu_grant` 0, `ref_start` 0, `ref_active` 0, `cpu_req_ready` 1.
- Tick to count: a tick at cycle t shows in `owed` at t+1.
- Idle refresh latency: with no CPU request, a tick at t gives `owed=1` at t+1, the IDLE decision at t+1, and `ref_start`/`ref_active` high at t+2.
- Refresh length: `ref_active` is high for exactly `REF_CYCLES` cycles. `owed` decrements at the end of the last one, and state is IDLE on the following cycle.
- Back-to-back refreshes: at least one IDLE cycle occurs between consecutive refreshes or between a refresh and a CPU grant.
- CPU grant: an accept at cycle t gives `cpu_grant` high from t+1 through the cycle `mem_done` is sampled; IDLE follows at the next cycle.
- Reset mid-refresh or mid-CPU access: immediate return to IDLE with `owed=0`. The in-flight operation is abandoned; the DRAM engine is reset by the same `rst_n`.

## Structure
- State enum (`z380_sched_state_t`) and default parameter constants live in `z380_platform_pkg`.
- One natural sub-module: `z380_refresh_debt`, a saturating up/down counter with a sticky overflow flag, parameterized by `MAX_OWED`.
- The FSM and the refresh cycle counter stay in the top module.

## Test plan
- Reset, then one tick with `cpu_req_valid=0` → `owed=1` at t+1, `ref_start` at t+2, `ref_active` for 6 cycles, then `owed=0` and IDLE.
- Tick while `cpu_req_valid=1`, `owed=1` → CPU accepted first; after `mem_done`, one IDLE cycle, then refresh; `owed` returns to 0.
- Hold a CPU access open (no `mem_done`) while 4 ticks arrive → after `mem_done`, `cpu_req_ready=0` with `owed=4`. Four refreshes run before the next CPU accept; `cpu_req_ready` rises once `owed` reaches 3.
- Eight ticks with the datapath blocked → `owed` saturates at 7 and `owed_ovf=1`. Then `ovf_clr` together with another tick leaves `owed_ovf=1`; `ovf_clr` alone gives `owed_ovf=0`.
- Tick coincident with the final refresh cycle at `owed=2` → `owed` stays 2, and another refresh follows.
- Assert `rst_n=0` during cycle 3 of a refresh → `ref_active=0`, `owed=0`, `cpu_req_ready=1` immediately, and the block stays idle after release.
